// File: rtl/dem_switch_splitter.sv
// DEM-DAC tree switching block: splits a signed Q(I.F) code x into top/bot
// with top+bot == x, using a first-order mismatch-shaped switching value s.
// One output register stage with valid/ready handshake on both sides.
// Optional feature macro: DEM_DITHER_EN (LFSR-dithered tie sign).

package lib_switchblock_pkg;
  localparam int I = 4;
  localparam int F = 4;
  localparam int W = I + F;
endpackage

module dem_switch_splitter
  import lib_switchblock_pkg::*;
`ifdef DEM_DITHER_EN
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)
`endif
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] x_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] top_o,
  output logic [W-1:0] bot_o,
  output logic [1:0]   s_o,
  output logic         valid_o,
  input  logic         ready_i
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [1:0] S_ZERO = 2'b00;
  localparam logic [1:0] S_POS  = 2'b01;
  localparam logic [1:0] S_NEG  = 2'b11;

  state_t       state_q, state_d;
  logic         q_q, q_d;
  logic [1:0]   s_d;
  logic         accept;
  logic         odd;
  logic [W:0]   x_ext, s_ext, sum_up, sum_dn;

`ifdef DEM_DITHER_EN
  logic [15:0]  lfsr_q;
  logic         owed_neg_q, owed_neg_d;
  logic         lfsr_fb;
`endif

  assign valid_o = (state_q == FULL);
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign odd     = x_i[0];

  // Output register FSM: next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (ready_i && !valid_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

`ifdef DEM_DITHER_EN
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Switching rule with dithered tie sign; q==1 repays the stored sign.
  always_comb begin
    s_d        = S_ZERO;
    q_d        = q_q;
    owed_neg_d = owed_neg_q;
    if (odd) begin
      if (q_q) begin
        s_d = owed_neg_q ? S_POS : S_NEG;
        q_d = 1'b0;
      end else begin
        s_d        = lfsr_q[15] ? S_POS : S_NEG;
        q_d        = 1'b1;
        owed_neg_d = !lfsr_q[15];
      end
    end
  end
`else
  // Deterministic switching rule: odd samples alternate +1/-1 starting at +1.
  always_comb begin
    s_d = S_ZERO;
    q_d = q_q;
    if (odd) begin
      s_d = q_q ? S_NEG : S_POS;
      q_d = !q_q;
    end
  end
`endif

  // Split arithmetic in W+1 bits; dropping bit 0 is the arithmetic shift right.
  always_comb begin
    x_ext  = {x_i[W-1], x_i};
    s_ext  = {{(W-1){s_d[1]}}, s_d};
    sum_up = x_ext + s_ext;
    sum_dn = x_ext - s_ext;
  end

  // State, switching memory and output register update.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q <= EMPTY;
      q_q     <= 1'b0;
      top_o   <= '0;
      bot_o   <= '0;
      s_o     <= S_ZERO;
    end else begin
      state_q <= state_d;
      if (accept) begin
        q_q   <= q_d;
        top_o <= sum_up[W:1];
        bot_o <= sum_dn[W:1];
        s_o   <= s_d;
      end
    end
  end

`ifdef DEM_DITHER_EN
  // Dither LFSR advances only on odd accepted samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q     <= LFSR_SEED;
      owed_neg_q <= 1'b0;
    end else if (accept && odd) begin
      lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
      owed_neg_q <= owed_neg_d;
    end
  end
`endif

endmodule
